mic_sample_framer: RTL

- Downstream consumer of the digital-mic ADC controller's 12-bit channel output; normally wired to CH0.
- Decimates the free-running channel value to a fixed sample rate and removes the mid-scale DC offset.
- Collects FRAME_LEN samples into ping-pong buffers and streams whole frames to the 64-point FFT over a valid/ready handshake.

---
 rtl/mic_sample_framer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mic_sample_framer.sv
// mic_sample_framer
// Decimates the free-running ADC channel value to a fixed sample rate, removes
// the mid-scale offset, collects FRAME_LEN samples into ping-pong banks and
// streams complete frames to the FFT over a valid/ready handshake.
//
// reader state | meaning
// RD_IDLE      | no frame in flight, waiting for the next bank to turn FULL
// RD_LOAD      | one-cycle synchronous RAM read of the first word of a frame
// RD_STREAM    | a word is presented; advance on each OUT_VALID && OUT_READY
//
// bank state    | meaning
// BANK_EMPTY    | free for the writer
// BANK_FILLING  | writer has started a frame here
// BANK_FULL     | complete frame waiting for the reader
// BANK_DRAINING | reader is streaming this bank

module mic_sample_framer #(
   parameter int SAMPLE_DIV = 6250,
   parameter int FRAME_LEN  = 64,
   parameter int IDX_W      = 6
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [11:0]      SAMPLE_IN,
   input  logic             CLEAR_OVF,
   input  logic             OUT_READY,
   output logic             OUT_VALID,
   output logic [11:0]      OUT_DATA,
   output logic [IDX_W-1:0] OUT_INDEX,
   output logic             OUT_LAST,
   output logic             OVERFLOW
);

   localparam int               CNT_W    = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_LOAD,
      RD_STREAM
   } rd_t;

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic             smp_vld;
   logic [11:0]      smp_data;
   bank_t            bank_st [2];
   logic             wr_bank;
   logic [IDX_W-1:0] wr_idx;
   rd_t              rd_state;
   logic             rd_bank;
   logic [IDX_W-1:0] rd_idx;
   logic [11:0]      mem [2*FRAME_LEN];
   logic             xfer;
   logic             rd_done;
   logic             wr_ok;

   assign tick    = (tick_cnt == CNT_LAST);
   assign xfer    = OUT_VALID & OUT_READY;
   assign rd_done = (rd_state == RD_STREAM) & xfer & OUT_LAST;

   // A bank being released by the reader this very cycle is already usable,
   // so a stalled writer does not lose the coincident tick.
   assign wr_ok = (bank_st[wr_bank] == BANK_EMPTY) |
                  (bank_st[wr_bank] == BANK_FILLING) |
                  (rd_done & (rd_bank == wr_bank));

   // Tick generation, offset removal (MSB inversion) and drop/overflow tracking.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         tick_cnt <= '0;
         smp_vld  <= 1'b0;
         smp_data <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         smp_vld  <= tick & wr_ok;
         if (tick) smp_data <= {~SAMPLE_IN[11], SAMPLE_IN[10:0]};
         if (tick & ~wr_ok) OVERFLOW <= 1'b1;
         else if (CLEAR_OVF) OVERFLOW <= 1'b0;
      end
   end

   // Frame RAM write port, fed from the registered capture stage.
   always_ff @(posedge CLOCK) begin
      if (smp_vld) mem[{wr_bank, wr_idx}] <= smp_data;
   end

   // Reader FSM, writer pointer and bank bookkeeping; they share bank_st.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         bank_st[0] <= BANK_EMPTY;
         bank_st[1] <= BANK_EMPTY;
         wr_bank    <= 1'b0;
         wr_idx     <= '0;
         rd_state   <= RD_IDLE;
         rd_bank    <= 1'b0;
         rd_idx     <= '0;
         OUT_VALID  <= 1'b0;
         OUT_DATA   <= '0;
         OUT_INDEX  <= '0;
         OUT_LAST   <= 1'b0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (bank_st[rd_bank] == BANK_FULL) begin
                  bank_st[rd_bank] <= BANK_DRAINING;
                  rd_idx           <= '0;
                  rd_state         <= RD_LOAD;
               end
            end
            RD_LOAD: begin
               OUT_VALID <= 1'b1;
               OUT_DATA  <= mem[{rd_bank, rd_idx}];
               OUT_INDEX <= rd_idx;
               OUT_LAST  <= (rd_idx == IDX_LAST);
               rd_idx    <= rd_idx + IDX_W'(1);
               rd_state  <= RD_STREAM;
            end
            RD_STREAM: begin
               if (xfer) begin
                  if (OUT_LAST) begin
                     OUT_VALID        <= 1'b0;
                     bank_st[rd_bank] <= BANK_EMPTY;
                     rd_bank          <= ~rd_bank;
                     rd_idx           <= '0;
                     if (bank_st[~rd_bank] == BANK_FULL) begin
                        bank_st[~rd_bank] <= BANK_DRAINING;
                        rd_state          <= RD_LOAD;
                     end else begin
                        rd_state <= RD_IDLE;
                     end
                  end else begin
                     OUT_DATA  <= mem[{rd_bank, rd_idx}];
                     OUT_INDEX <= rd_idx;
                     OUT_LAST  <= (rd_idx == IDX_LAST);
                     rd_idx    <= rd_idx + IDX_W'(1);
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase

         // Writer update comes last so a same-cycle release then refill ends FILLING.
         if (smp_vld) begin
            if (wr_idx == IDX_LAST) begin
               bank_st[wr_bank] <= BANK_FULL;
               wr_idx           <= '0;
               wr_bank          <= ~wr_bank;
            end else begin
               bank_st[wr_bank] <= BANK_FILLING;
               wr_idx           <= wr_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule
